mux_sel_serializer: RTL and testbench
=====================================

Name: mux_sel_serializer

Overview:
Parallel-to-serial stage that directly drives the select input of the 8:1 mux. It accepts an 8-bit word over a valid/ready handshake and holds it as the mux data input. It then steps the 3-bit select through all eight positions, one per clock, and emits a framed serial bitstream. Back-to-back words stream with no idle cycles, and a wrapping counter reports completed words.

Parameters:
MSB_FIRST, 0, 0 = bit 0 sent first (sel counts 0->7); 1 = bit 7 sent first (sel counts 7->0)
CNT_W, 16, width of the completed-word counter

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  upstream word available
in_ready  out  1  block can accept a word this cycle
in_data  in  8  parallel word, sampled when in_valid && in_ready
sel  out  3  current select index driven into the mux
ser_out  out  1  serial bit = data_reg[sel] gated by ser_valid
ser_valid  out  1  ser_out carries a valid bit this cycle
frame_start  out  1  high on the first bit of a word
frame_end  out  1  high on the last bit of a word
busy  out  1  state == SHIFT
word_cnt  out  CNT_W  completed words, wraps to 0

Behaviour:
- Reset (async assert, sync-to-clk deassert assumed upstream):
  - state = IDLE; data_reg = 0; sel = FIRST (0 if MSB_FIRST=0, else 7).
  - word_cnt = 0; ser_valid = 0; ser_out = 0; frame_start/frame_end = 0; busy = 0; in_ready = 1 after reset release.
- Constants: FIRST = MSB_FIRST ? 7 : 0; LAST = MSB_FIRST ? 0 : 7.
- FSM states: IDLE, SHIFT.
  - IDLE: in_ready = 1. On in_valid, data_reg <= in_data, sel <= FIRST, go to SHIFT.
  - SHIFT: ser_valid = 1, busy = 1, ser_out = mux(data_reg, sel). Each cycle sel steps +1 (MSB_FIRST=0) or -1 (MSB_FIRST=1).
- Last bit (sel == LAST):
  - in_ready = 1 and frame_end = 1.
  - If in_valid, load new word, sel <= FIRST, stay in SHIFT (zero-gap streaming).
  - Otherwise return to IDLE.
  - word_cnt increments at that edge either way.
- in_ready = (state==IDLE) || (state==SHIFT && sel==LAST). It is combinational from state; it never depends on in_valid.
- in_data is ignored whenever in_ready = 0; data_reg is stable for all 8 SHIFT cycles of a word.
- Latency: word accepted at edge N; its first bit is on ser_out in the cycle after edge N; its last bit is in the cycle after edge N+7.
- Throughput: 1 word / 8 clk when streaming.
- frame_start = ser_valid && sel==FIRST.
- Outputs in IDLE: ser_out forced 0; sel holds FIRST.
- word_cnt wrap: all-ones -> 0 at the next completion, no saturation or flag.
- Reset mid-word: the word in flight is discarded, the FSM returns to IDLE, word_cnt is cleared, and no partial frame_end is produced.
- in_valid dropping mid-frame has no effect; a frame, once started, always completes 8 bits.

Decomposition:
- Shared package holds:
  - ST_IDLE/ST_SHIFT state encoding (1-bit);
  - DATA_W=8 and SEL_W=3 constants;
  - FIRST/LAST select-index functions of MSB_FIRST.
- One sub-module, the existing mux_8x1, instantiated with I=data_reg, S=sel, Y=mux_y. ser_out = mux_y & ser_valid.
- FSM, sel counter and word counter stay in the top-level body.

Test Plan:
- Reset, MSB_FIRST=0:
  - hold rst_n=0 for 3 clk -> all outputs 0, sel=0, in_ready=0 during reset and 1 after release.
  - Then pulse in_valid with in_data=8'b01100101 -> over 8 cycles ser_out=1,0,1,0,0,1,1,0 with sel=0..7.
  - frame_start only with sel=0, frame_end only with sel=7, word_cnt=1 afterwards, then back to IDLE.
- MSB_FIRST=1, same word 8'b01100101 -> ser_out=0,1,1,0,0,1,0,1 with sel=7..0; frame_end with sel=0.
- Back-to-back: hold in_valid=1 with words 8'hA5 then 8'h3C -> 16 contiguous ser_valid cycles, in_ready high only on cycles 8 and 16, word_cnt=2, no gap bit.
- in_data changes mid-frame (8'hFF->8'h00 while busy, in_valid=1) -> the current frame still sends 8'hFF bits; 8'h00 is loaded only on the frame_end edge.
- Reset mid-operation: assert rst_n=0 asynchronously (between edges) after the 4th bit -> ser_valid, busy and word_cnt are 0 immediately, and no frame_end pulse occurs.
- Counter wrap: CNT_W=4, stream 16 words -> word_cnt goes 15 -> 0 on the 16th frame_end.

Source files
------------

// File: rtl/mux_sel_serializer_pkg.sv
// Shared constants and state encoding for the select-driving serializer.
package mux_sel_serializer_pkg;

    localparam int DATA_W = 8;
    localparam int SEL_W  = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    function automatic logic [SEL_W-1:0] first_sel(input int msb_first);
        return (msb_first != 0) ? 3'd7 : 3'd0;
    endfunction

    function automatic logic [SEL_W-1:0] last_sel(input int msb_first);
        return (msb_first != 0) ? 3'd0 : 3'd7;
    endfunction

endpackage

// File: rtl/mux_8x1.sv
// 8:1 bit multiplexer: Y = I[S].
module mux_8x1 (
    input  logic [7:0] I,
    input  logic [2:0] S,
    output logic       Y
);

    always_comb begin
        Y = I[S];
    end

endmodule

// File: rtl/mux_sel_serializer.sv
// Parallel-to-serial stage stepping the 8:1 mux select; zero-gap word streaming.
module mux_sel_serializer
    import mux_sel_serializer_pkg::*;
#(
    parameter int MSB_FIRST = 0,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic [SEL_W-1:0]  sel,
    output logic              ser_out,
    output logic              ser_valid,
    output logic              frame_start,
    output logic              frame_end,
    output logic              busy,
    output logic [CNT_W-1:0]  word_cnt
);

    localparam logic [SEL_W-1:0] FIRST = first_sel(MSB_FIRST);
    localparam logic [SEL_W-1:0] LAST  = last_sel(MSB_FIRST);

    state_e              state_q;
    logic [DATA_W-1:0]   data_q;
    logic [SEL_W-1:0]    sel_q;
    logic [SEL_W-1:0]    sel_d;
    logic [CNT_W-1:0]    cnt_q;
    logic                shifting;
    logic                at_last;
    logic                load;
    logic                mux_y;

    assign shifting = (state_q == ST_SHIFT);
    assign at_last  = shifting && (sel_q == LAST);
    // Gated by rst_n so the handshake stays closed while reset is held.
    assign in_ready = rst_n && ((state_q == ST_IDLE) || at_last);
    assign load     = in_valid && in_ready;

    always_comb begin
        sel_d = sel_q;
        if (load || at_last) begin
            sel_d = FIRST;
        end else if (shifting) begin
            sel_d = (MSB_FIRST != 0) ? sel_q - 3'd1 : sel_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            sel_q   <= FIRST;
            cnt_q   <= '0;
        end else begin
            sel_q <= sel_d;
            if (load) begin
                data_q <= in_data;
            end
            if (at_last) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        state_q <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (at_last && !in_valid) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    mux_8x1 u_mux (
        .I (data_q),
        .S (sel_q),
        .Y (mux_y)
    );

    assign sel         = sel_q;
    assign busy        = shifting;
    assign ser_valid   = shifting;
    assign ser_out     = mux_y & shifting;
    assign frame_start = shifting && (sel_q == FIRST);
    assign frame_end   = at_last;
    assign word_cnt    = cnt_q;

endmodule

// File: tb/tb_mux_sel_serializer.sv
// Directed self-checking bench for mux_sel_serializer (LSB-first, MSB-first, 4-bit counter wrap).
module tb_mux_sel_serializer;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_data;
    int         checks;
    int         errors;

    logic        v0, rdy0, so0, sv0, fs0, fe0, b0;
    logic [2:0]  sel0;
    logic [15:0] cnt0;
    logic        v1, rdy1, so1, sv1, fs1, fe1, b1;
    logic [2:0]  sel1;
    logic [15:0] cnt1;
    logic        vw, rdyw, sow, svw, fsw, few, bw;
    logic [2:0]  selw;
    logic [3:0]  cntw;

    logic [8:0] obs0, obs1, exp9;
    assign obs0 = {sv0, so0, fs0, fe0, b0, rdy0, sel0};
    assign obs1 = {sv1, so1, fs1, fe1, b1, rdy1, sel1};

    bit exp_lsb [8]  = '{1, 0, 1, 0, 0, 1, 1, 0};
    bit exp_msb [8]  = '{0, 1, 1, 0, 0, 1, 0, 1};
    bit exp_b2b [16] = '{1, 0, 1, 0, 0, 1, 0, 1, 0, 0, 1, 1, 1, 1, 0, 0};

    mux_sel_serializer #(.MSB_FIRST(0), .CNT_W(16)) u_lsb (
        .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_ready(rdy0), .in_data(in_data),
        .sel(sel0), .ser_out(so0), .ser_valid(sv0), .frame_start(fs0), .frame_end(fe0),
        .busy(b0), .word_cnt(cnt0)
    );

    mux_sel_serializer #(.MSB_FIRST(1), .CNT_W(16)) u_msb (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(rdy1), .in_data(in_data),
        .sel(sel1), .ser_out(so1), .ser_valid(sv1), .frame_start(fs1), .frame_end(fe1),
        .busy(b1), .word_cnt(cnt1)
    );

    mux_sel_serializer #(.MSB_FIRST(0), .CNT_W(4)) u_wrap (
        .clk(clk), .rst_n(rst_n), .in_valid(vw), .in_ready(rdyw), .in_data(in_data),
        .sel(selw), .ser_out(sow), .ser_valid(svw), .frame_start(fsw), .frame_end(few),
        .busy(bw), .word_cnt(cntw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (obs0 !== 9'b000000_000 || cnt0 !== 16'd0) begin
            errors++;
            $display("FAIL reset_lsb: got obs=%b cnt=%0d, expected obs=000000000 cnt=0", obs0, cnt0);
        end
        checks++;
        if (obs1 !== 9'b000000_111 || cnt1 !== 16'd0) begin
            errors++;
            $display("FAIL reset_msb: got obs=%b cnt=%0d, expected obs=000000111 cnt=0", obs1, cnt1);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (obs0 !== 9'b000001_000) begin
            errors++;
            $display("FAIL reset_release: got obs=%b, expected 000001000", obs0);
        end
    endtask

    task automatic test_lsb_first();
        do_reset();
        v0 = 1'b1;
        in_data = 8'b01100101;
        @(posedge clk);
        #1 v0 = 1'b0;
        in_data = 8'h00;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            exp9 = {1'b1, exp_lsb[i], (i == 0), (i == 7), 1'b1, (i == 7), 3'(i)};
            checks++;
            if (obs0 !== exp9) begin
                errors++;
                $display("FAIL lsb_bit%0d: got %b, expected %b", i, obs0, exp9);
            end
        end
        @(negedge clk);
        checks++;
        if (obs0 !== 9'b000001_000 || cnt0 !== 16'd1) begin
            errors++;
            $display("FAIL lsb_done: got obs=%b cnt=%0d, expected obs=000001000 cnt=1", obs0, cnt0);
        end
    endtask

    task automatic test_msb_first();
        do_reset();
        v1 = 1'b1;
        in_data = 8'b01100101;
        @(posedge clk);
        #1 v1 = 1'b0;
        in_data = 8'h00;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            exp9 = {1'b1, exp_msb[i], (i == 0), (i == 7), 1'b1, (i == 7), 3'(7 - i)};
            checks++;
            if (obs1 !== exp9) begin
                errors++;
                $display("FAIL msb_bit%0d: got %b, expected %b", i, obs1, exp9);
            end
        end
        @(negedge clk);
        checks++;
        if (obs1 !== 9'b000001_111 || cnt1 !== 16'd1) begin
            errors++;
            $display("FAIL msb_done: got obs=%b cnt=%0d, expected obs=000001111 cnt=1", obs1, cnt1);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        v0 = 1'b1;
        in_data = 8'hA5;
        @(posedge clk);
        #1 in_data = 8'h3C;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 8) v0 = 1'b0;
            exp9 = {1'b1, exp_b2b[i], (i % 8 == 0), (i % 8 == 7), 1'b1, (i % 8 == 7), 3'(i % 8)};
            checks++;
            if (obs0 !== exp9) begin
                errors++;
                $display("FAIL b2b_bit%0d: got %b, expected %b", i, obs0, exp9);
            end
        end
        @(negedge clk);
        checks++;
        if (sv0 !== 1'b0 || cnt0 !== 16'd2) begin
            errors++;
            $display("FAIL b2b_done: got ser_valid=%b cnt=%0d, expected ser_valid=0 cnt=2", sv0, cnt0);
        end
    endtask

    task automatic test_data_change_mid_frame();
        do_reset();
        v0 = 1'b1;
        in_data = 8'hFF;
        @(posedge clk);
        #1 in_data = 8'h00;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 8) v0 = 1'b0;
            checks++;
            if (so0 !== (i < 8) || sv0 !== 1'b1) begin
                errors++;
                $display("FAIL midchg_bit%0d: got ser_out=%b ser_valid=%b, expected ser_out=%b ser_valid=1",
                         i, so0, sv0, (i < 8));
            end
        end
        @(negedge clk);
        checks++;
        if (cnt0 !== 16'd2) begin
            errors++;
            $display("FAIL midchg_cnt: got %0d, expected 2", cnt0);
        end
    endtask

    task automatic test_reset_mid_word();
        do_reset();
        v0 = 1'b1;
        in_data = 8'h0F;
        @(posedge clk);
        #1 v0 = 1'b0;
        repeat (9) @(negedge clk);
        checks++;
        if (cnt0 !== 16'd1) begin
            errors++;
            $display("FAIL rstmid_pre_cnt: got %0d, expected 1", cnt0);
        end
        v0 = 1'b1;
        in_data = 8'hFF;
        @(posedge clk);
        #1 v0 = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({sv0, b0, fe0, so0} !== 4'b0000 || cnt0 !== 16'd0) begin
            errors++;
            $display("FAIL rstmid_async: got sv/busy/fe/so=%b cnt=%0d, expected 0000 cnt=0",
                     {sv0, b0, fe0, so0}, cnt0);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 3) rst_n = 1'b1;
            checks++;
            if (fe0 !== 1'b0 || sv0 !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_cyc%0d: got frame_end=%b ser_valid=%b, expected 0 0", i, fe0, sv0);
            end
        end
    endtask

    task automatic test_counter_wrap();
        do_reset();
        vw = 1'b1;
        in_data = 8'h5A;
        for (int w = 0; w < 16; w++) begin
            for (int b = 0; b < 8; b++) begin
                @(negedge clk);
                if (b == 7) begin
                    checks++;
                    if (few !== 1'b1 || cntw !== 4'(w)) begin
                        errors++;
                        $display("FAIL wrap_word%0d: got frame_end=%b cnt=%0d, expected frame_end=1 cnt=%0d",
                                 w, few, cntw, w);
                    end
                    if (w == 15) vw = 1'b0;
                end
            end
        end
        @(negedge clk);
        checks++;
        if (cntw !== 4'd0 || svw !== 1'b0) begin
            errors++;
            $display("FAIL wrap_final: got cnt=%0d ser_valid=%b, expected cnt=0 ser_valid=0", cntw, svw);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        v0      = 1'b0;
        v1      = 1'b0;
        vw      = 1'b0;
        in_data = 8'h00;
        test_reset();
        test_lsb_first();
        test_msb_first();
        test_back_to_back();
        test_data_change_mid_frame();
        test_reset_mid_word();
        test_counter_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion before 200000");
        $fatal(1);
    end

endmodule
